regfile_scoreboard: RTL

Parametrised decode-stage register file with write-to-read bypass and a per-register scoreboard of in-flight writes. It replaces fixed 2-read/8-entry storage and ad-hoc destination compares with pending-write counters, and it produces the decode stall that inserts NOPs. It sits in decode: writeback drives the write port, decode drives the issue/read ports, and branch squash retires killed writers.

---
 rtl/regfile_scoreboard.sv | 136 +++++++++++++
 1 files changed

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : regfile_scoreboard
// Purpose  : Decode-stage register file with write-to-read bypass and a
//            per-register pending-write counter scoreboard that produces
//            the decode stall (RAW hazard and WAW counter back-pressure).
// Revision : 1.0 - initial release
// ============================================================================
module regfile_scoreboard #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int NUM_RD = 2,
    parameter int CNT_W  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       iss_valid,
    input  logic                       iss_wr_en,
    input  logic [ADDR_W-1:0]          iss_rd,
    input  logic [NUM_RD-1:0]          rd_use,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_sel,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    input  logic                       wb_en,
    input  logic [ADDR_W-1:0]          wb_sel,
    input  logic [DATA_W-1:0]          wb_data,
    input  logic                       squash_en,
    input  logic [ADDR_W-1:0]          squash_sel,
    output logic                       stall,
    output logic                       busy,
    output logic                       err
);

    localparam int                 NUM_REGS = 1 << ADDR_W;
    localparam logic [CNT_W-1:0]   PMAX     = '1;

    // Architectural storage and scoreboard state
    logic [DATA_W-1:0] regs    [NUM_REGS];
    logic [CNT_W-1:0]  pending [NUM_REGS];

    // Per-register next-state terms
    logic [CNT_W-1:0]  pend_nxt  [NUM_REGS];
    logic [NUM_REGS-1:0] uflow;
    logic [NUM_RD-1:0]   port_need;

    logic waw_full;
    logic accept;

    // ------------------------------------------------------------------
    // Read ports: writeback data bypasses the array on a select match,
    // independent of whether the operand is actually used.  A port needs
    // to stall when its register still has a writer outstanding after
    // accounting for a writeback landing this very cycle.
    // ------------------------------------------------------------------
    generate
        for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
            logic [ADDR_W-1:0] sel;
            logic              hit;

            assign sel = rd_sel[i*ADDR_W +: ADDR_W];
            assign hit = wb_en && (wb_sel == sel);
            assign rd_data[i*DATA_W +: DATA_W] = hit ? wb_data : regs[sel];
            assign port_need[i] = rd_use[i] && (pending[sel] > CNT_W'(hit));
        end
    endgenerate

    // A counter already at its ceiling cannot take another writer; uses
    // the registered count so a same-cycle writeback does not release it.
    assign waw_full = iss_wr_en && (pending[iss_rd] == PMAX);
    assign stall    = iss_valid && ((|port_need) || waw_full);
    assign accept   = iss_valid && !stall;

    // ------------------------------------------------------------------
    // Counter arithmetic: +1 for an accepted writer, -1 each for a
    // writeback and a squash.  Going below zero clamps and flags error.
    // Overflow is impossible because a writer to a full counter stalls.
    // ------------------------------------------------------------------
    generate
        for (genvar r = 0; r < NUM_REGS; r++) begin : g_cnt
            logic           inc;
            logic [1:0]     dec;
            logic [CNT_W:0] sum;
            logic [CNT_W:0] diff;

            assign inc  = accept && iss_wr_en && (iss_rd == ADDR_W'(r));
            assign dec  = {1'b0, wb_en && (wb_sel == ADDR_W'(r))}
                        + {1'b0, squash_en && (squash_sel == ADDR_W'(r))};
            assign sum  = {1'b0, pending[r]} + {{CNT_W{1'b0}}, inc};
            assign diff = sum - (CNT_W+1)'(dec);
            assign uflow[r]    = ((CNT_W+1)'(dec) > sum);
            assign pend_nxt[r] = uflow[r] ? '0 : diff[CNT_W-1:0];
        end
    endgenerate

    // Register array write from the writeback port
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs[r] <= '0;
            end
        end else if (wb_en) begin
            regs[wb_sel] <= wb_data;
        end
    end

    // Pending-write counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                pending[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                pending[r] <= pend_nxt[r];
            end
        end
    end

    // Sticky underflow error
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err <= 1'b0;
        end else if (|uflow) begin
            err <= 1'b1;
        end
    end

    // Any outstanding writer, from registered state only
    always_comb begin
        busy = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            busy = busy | (pending[r] != '0);
        end
    end

endmodule
`default_nettype wire
